// File: rtl/uart_test_pkg.sv
// Shared types and constants for the UART loopback pattern generator.
package uart_test_pkg;

    typedef enum logic [1:0] {
        INC   = 2'd0,
        LFSR  = 2'd1,
        WALK1 = 2'd2,
        ALT   = 2'd3
    } pattern_mode_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RX,
        GAP,
        DONE
    } state_t;

    localparam logic [7:0] LFSR_POLY = 8'hB8;
    localparam logic [7:0] ALT_A     = 8'h55;
    localparam logic [7:0] ALT_B     = 8'hAA;

endpackage

// File: rtl/uart_pattern_src.sv
// Pattern register: loads the first byte of the selected mode, then steps it on advance.
module uart_pattern_src
    import uart_test_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic          i_clk,
    input  logic          i_aresetn,
    input  logic          load,
    input  logic          advance,
    input  pattern_mode_t mode,
    output logic [7:0]    pattern
);

    // An all-zero LFSR state would lock up, so a zero seed starts at 0x01 instead.
    localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    pattern_mode_t cur_mode;
    logic [7:0]    first_val;
    logic [7:0]    next_val;

    always_comb begin
        first_val = 8'h00;
        case (mode)
            INC:     first_val = 8'h00;
            LFSR:    first_val = SEED;
            WALK1:   first_val = 8'h01;
            ALT:     first_val = ALT_A;
            default: first_val = 8'h00;
        endcase
    end

    always_comb begin
        next_val = pattern;
        case (cur_mode)
            INC:     next_val = pattern + 8'd1;
            LFSR:    next_val = (pattern >> 1) ^ (pattern[0] ? LFSR_POLY : 8'h00);
            WALK1:   next_val = {pattern[6:0], pattern[7]};
            ALT:     next_val = (pattern == ALT_A) ? ALT_B : ALT_A;
            default: next_val = pattern;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            cur_mode <= INC;
            pattern  <= 8'h00;
        end else if (load) begin
            cur_mode <= mode;
            pattern  <= first_val;
        end else if (advance) begin
            pattern  <= next_val;
        end
    end

endmodule

// File: rtl/uart_test_pattern_gen.sv
// Drives a run of test bytes into uart_tx, pacing each byte on uart_rx's done pulse with a timeout.
module uart_test_pattern_gen
    import uart_test_pkg::*;
#(
    parameter int          NUM_TESTS      = 16,
    parameter int          GAP_CYCLES     = 100,
    parameter int          TIMEOUT_CYCLES = 200000,
    parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
    input  logic        i_clk,
    input  logic        i_aresetn,
    input  logic        i_start,
    input  logic [1:0]  i_mode,
    input  logic        i_tx_busy,
    input  logic        i_rx_done,
    output logic        o_tx_start,
    output logic [7:0]  o_tx_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_timeout,
    output logic [15:0] o_sent_cnt
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [15:0]      LAST_COUNT = 16'(NUM_TESTS);

    state_t           state;
    logic [TMO_W-1:0] tmo_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             pattern_load;
    logic             pattern_advance;

    assign pattern_load    = ((state == IDLE) || (state == DONE)) && i_start;
    assign pattern_advance = (state == WAIT_RX) && i_rx_done;

    uart_pattern_src #(
        .LFSR_SEED (LFSR_SEED)
    ) u_pattern_src (
        .i_clk     (i_clk),
        .i_aresetn (i_aresetn),
        .load      (pattern_load),
        .advance   (pattern_advance),
        .mode      (pattern_mode_t'(i_mode)),
        .pattern   (o_tx_data)
    );

    // The WAIT_RX window lasts TIMEOUT_CYCLES clocks, counted from the o_tx_start cycle.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            gap_cnt    <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_timeout  <= 1'b0;
            o_sent_cnt <= 16'd0;
        end else begin
            o_tx_start <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        o_sent_cnt <= 16'd0;
                        o_done     <= 1'b0;
                        o_timeout  <= 1'b0;
                        o_busy     <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!i_tx_busy) begin
                        o_tx_start <= 1'b1;
                        tmo_cnt    <= TMO_LOAD;
                        state      <= WAIT_RX;
                    end
                end
                WAIT_RX: begin
                    if (i_rx_done) begin
                        o_sent_cnt <= o_sent_cnt + 16'd1;
                        if (o_sent_cnt + 16'd1 == LAST_COUNT) begin
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                            state  <= DONE;
                        end else if (GAP_CYCLES > 0) begin
                            gap_cnt <= GAP_LOAD;
                            state   <= GAP;
                        end else begin
                            state <= ISSUE;
                        end
                    end else if (tmo_cnt == '0) begin
                        o_timeout <= 1'b1;
                        o_busy    <= 1'b0;
                        o_done    <= 1'b1;
                        state     <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt - TMO_W'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= ISSUE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_test_pattern_gen.sv
// Randomized self-checking bench for uart_test_pattern_gen against an index-based pattern model.
module tb_uart_test_pattern_gen;

    localparam int         A_NUM  = 10;
    localparam int         A_GAP  = 2;
    localparam int         A_TMO  = 50;
    localparam logic [7:0] A_SEED = 8'hA5;
    localparam int         B_NUM  = 3;
    localparam int         B_GAP  = 0;
    localparam int         B_TMO  = 20;
    localparam logic [7:0] B_SEED = 8'h00;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_start, a_tx_busy, a_rx_done;
    logic [1:0]  a_mode;
    logic        a_tx_start, a_busy, a_done, a_timeout;
    logic [7:0]  a_tx_data;
    logic [15:0] a_sent_cnt;

    logic        b_start;
    logic [1:0]  b_mode;
    logic        b_tx_start, b_busy, b_done, b_timeout;
    logic [7:0]  b_tx_data;
    logic [15:0] b_sent_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int a_pulses = 0;
    int b_pulses = 0;
    int a_last_start = 0;
    logic [7:0] a_bytes[$];
    logic [7:0] b_bytes[$];
    bit rsp_enable = 1'b0;
    bit rsp_same = 1'b0;
    bit rsp_stray = 1'b0;

    uart_test_pattern_gen #(
        .NUM_TESTS(A_NUM), .GAP_CYCLES(A_GAP), .TIMEOUT_CYCLES(A_TMO), .LFSR_SEED(A_SEED)
    ) dut_a (
        .i_clk(clk), .i_aresetn(rst_n), .i_start(a_start), .i_mode(a_mode),
        .i_tx_busy(a_tx_busy), .i_rx_done(a_rx_done),
        .o_tx_start(a_tx_start), .o_tx_data(a_tx_data), .o_busy(a_busy),
        .o_done(a_done), .o_timeout(a_timeout), .o_sent_cnt(a_sent_cnt)
    );

    // Second instance loops its own start pulse back as rx_done: same-cycle acknowledge, no gap, zero seed.
    uart_test_pattern_gen #(
        .NUM_TESTS(B_NUM), .GAP_CYCLES(B_GAP), .TIMEOUT_CYCLES(B_TMO), .LFSR_SEED(B_SEED)
    ) dut_b (
        .i_clk(clk), .i_aresetn(rst_n), .i_start(b_start), .i_mode(b_mode),
        .i_tx_busy(1'b0), .i_rx_done(b_tx_start),
        .o_tx_start(b_tx_start), .o_tx_data(b_tx_data), .o_busy(b_busy),
        .o_done(b_done), .o_timeout(b_timeout), .o_sent_cnt(b_sent_cnt)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_tx_start) begin
            a_bytes.push_back(a_tx_data);
            a_pulses     = a_pulses + 1;
            a_last_start = cyc;
        end
        if (b_tx_start) begin
            b_bytes.push_back(b_tx_data);
            b_pulses = b_pulses + 1;
        end
    end

    // Receiver stand-in: acknowledges each byte after a random delay, optionally adding a stray pulse in GAP.
    initial begin
        int d;
        a_rx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_enable && a_tx_start) begin
                d = rsp_same ? 0 : int'($urandom_range(0, 10));
                repeat (d) @(negedge clk);
                a_rx_done = 1'b1;
                @(negedge clk);
                a_rx_done = 1'b0;
                if (rsp_stray) begin
                    @(negedge clk);
                    a_rx_done = 1'b1;
                    @(negedge clk);
                    a_rx_done = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] expByte(input int mode, input int k, input logic [7:0] seed);
        logic [7:0] x;
        case (mode)
            0: return 8'(k % 256);
            1: begin
                x = (seed == 8'h00) ? 8'h01 : seed;
                for (int i = 0; i < k; i++) x = (x >> 1) ^ (x[0] ? 8'hB8 : 8'h00);
                return x;
            end
            2: return 8'(1 << (k % 8));
            default: return (k % 2 == 0) ? 8'h55 : 8'hAA;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
        checks++;
        if (got !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int mode, input bit stray, input bit same,
                                 input bit interrupt, input int busy_hold);
        int base_n;
        int base_q;
        base_n     = a_pulses;
        base_q     = a_bytes.size();
        rsp_enable = 1'b1;
        rsp_same   = same;
        rsp_stray  = stray;
        a_tx_busy  = (busy_hold > 0);
        a_start    = 1'b1;
        a_mode     = 2'(mode);
        tick();
        a_start = 1'b0;
        a_mode  = 2'($urandom);
        checkOutput("run_busy", 32'(a_busy), 1);
        checkOutput("run_timeout_clear", 32'(a_timeout), 0);
        checkOutput("run_cnt_clear", 32'(a_sent_cnt), 0);
        if (busy_hold > 0) begin
            repeat (busy_hold) tick();
            checkOutput("busy_no_start", 32'(a_pulses - base_n), 0);
            a_tx_busy = 1'b0;
            tick();
            checkOutput("start_after_busy", 32'(a_pulses - base_n), 1);
        end
        if (interrupt) begin
            for (int i = 0; i < 200 && a_pulses == base_n; i++) tick();
            tick();
            a_start = 1'b1;
            a_mode  = 2'(mode + 1);
            tick();
            a_start = 1'b0;
        end
        for (int i = 0; i < 3000 && !a_done; i++) tick();
        checkOutput("run_done", 32'(a_done), 1);
        checkOutput("run_idle", 32'(a_busy), 0);
        checkOutput("run_no_timeout", 32'(a_timeout), 0);
        checkOutput("run_sent_cnt", 32'(a_sent_cnt), A_NUM);
        checkOutput("run_pulses", 32'(a_pulses - base_n), A_NUM);
        for (int k = 0; k < A_NUM; k++) begin
            if (base_q + k < a_bytes.size())
                checkOutput($sformatf("mode%0d_byte%0d", mode, k), 32'(a_bytes[base_q + k]),
                            32'(expByte(mode, k, A_SEED)));
        end
        repeat (4) tick();
    endtask

    task automatic runB(input int mode);
        int base_n;
        int base_q;
        base_n  = b_pulses;
        base_q  = b_bytes.size();
        b_start = 1'b1;
        b_mode  = 2'(mode);
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 200 && !b_done; i++) tick();
        checkOutput("b_done", 32'(b_done), 1);
        checkOutput("b_sent_cnt", 32'(b_sent_cnt), B_NUM);
        checkOutput("b_pulses", 32'(b_pulses - base_n), B_NUM);
        for (int k = 0; k < B_NUM; k++) begin
            if (base_q + k < b_bytes.size())
                checkOutput($sformatf("b_mode%0d_byte%0d", mode, k), 32'(b_bytes[base_q + k]),
                            32'(expByte(mode, k, B_SEED)));
        end
        repeat (2) tick();
    endtask

    initial begin
        int base_n;
        int lat;
        a_start   = 1'b0;
        a_mode    = 2'd0;
        a_tx_busy = 1'b0;
        b_start   = 1'b0;
        b_mode    = 2'd0;
        repeat (3) tick();
        checkOutput("reset_a", {a_tx_start, a_tx_data, a_busy, a_done, a_timeout, a_sent_cnt}, 0);
        checkOutput("reset_b", {b_tx_start, b_tx_data, b_busy, b_done, b_timeout, b_sent_cnt}, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        applyStimulus(0, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 0);
        applyStimulus(3, 1'b0, 1'b1, 1'b0, 0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 50);
        applyStimulus(1, 1'b0, 1'b0, 1'b1, 0);

        // Timeout: nobody acknowledges the first byte.
        rsp_enable = 1'b0;
        base_n     = a_pulses;
        a_start    = 1'b1;
        a_mode     = 2'd0;
        tick();
        a_start = 1'b0;
        for (int i = 0; i < 100 && a_pulses == base_n; i++) tick();
        for (int i = 0; i < 200 && !a_done; i++) tick();
        lat = cyc - a_last_start;
        checkOutput("timeout_flag", 32'(a_timeout), 1);
        checkOutput("timeout_done", 32'(a_done), 1);
        checkOutput("timeout_idle", 32'(a_busy), 0);
        checkOutput("timeout_cnt", 32'(a_sent_cnt), 0);
        checkOutput("timeout_pulses", 32'(a_pulses - base_n), 1);
        checkOutput("timeout_latency", 32'(lat >= A_TMO && lat <= A_TMO + 1), 1);
        repeat (2) tick();
        applyStimulus(int'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0, 0);

        // Reset in the middle of WAIT_RX.
        rsp_enable = 1'b0;
        base_n     = a_pulses;
        a_start    = 1'b1;
        a_mode     = 2'd1;
        tick();
        a_start = 1'b0;
        for (int i = 0; i < 100 && a_pulses == base_n; i++) tick();
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midrun_reset", {a_tx_start, a_tx_data, a_busy, a_done, a_timeout, a_sent_cnt}, 0);
        base_n = a_pulses;
        repeat (5) tick();
        rst_n = 1'b1;
        repeat (60) tick();
        checkOutput("after_reset_pulses", 32'(a_pulses - base_n), 0);
        checkOutput("after_reset_idle", {a_busy, a_done, a_timeout}, 0);
        applyStimulus(2, 1'b0, 1'b0, 1'b0, 0);

        runB(1);
        runB(int'($urandom_range(0, 3)));

        for (int r = 0; r < 4; r++)
            applyStimulus(int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
